// File: rtl/alu_if_pkg.sv
// Shared types and encodings for the ALU operand-interface issuer.
package alu_if_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBeat1,
    StGap,
    StBeat2,
    StWait,
    StResp
  } state_e;

  localparam logic [1:0] IV_NONE = 2'b00;
  localparam logic [1:0] IV_A    = 2'b01;
  localparam logic [1:0] IV_B    = 2'b10;
  localparam logic [1:0] IV_AB   = 2'b11;

  localparam logic [1:0] SPLIT_AB     = 2'b00;
  localparam logic [1:0] SPLIT_A_B    = 2'b01;
  localparam logic [1:0] SPLIT_B_A    = 2'b10;
  localparam logic [1:0] SPLIT_AB_ALT = 2'b11;

  localparam logic        MODE_ARITH  = 1'b1;
  localparam int unsigned CMD_MUL_INC = 9;
  localparam int unsigned CMD_MUL_SHL = 10;

  localparam int unsigned FLAG_COUT  = 5;
  localparam int unsigned FLAG_OFLOW = 4;
  localparam int unsigned FLAG_G     = 3;
  localparam int unsigned FLAG_E     = 2;
  localparam int unsigned FLAG_L     = 1;
  localparam int unsigned FLAG_ERR   = 0;

  // z and x on an ALU line are treated as 0.
  function automatic logic definite_one(input logic b);
    return (b === 1'b1);
  endfunction

endpackage

// File: rtl/alu_op_issuer.sv
// Issues one ALU transaction (joint or split operand beats), waits the command latency,
// captures the ALU result/flags and returns them on a valid/ready response port.
module alu_op_issuer
  import alu_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CMD_WIDTH  = 4,
  parameter int unsigned RES_LAT    = 1,
  parameter int unsigned MULT_LAT   = 3,
  parameter int unsigned TMO_LIMIT  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [DATA_WIDTH-1:0] REQ_OPA,
  input  logic [DATA_WIDTH-1:0] REQ_OPB,
  input  logic [CMD_WIDTH-1:0]  REQ_CMD,
  input  logic                  REQ_MODE,
  input  logic                  REQ_CIN,
  input  logic [1:0]            REQ_SPLIT,
  input  logic [4:0]            REQ_GAP,
  output logic [DATA_WIDTH-1:0] OPA,
  output logic [DATA_WIDTH-1:0] OPB,
  output logic [CMD_WIDTH-1:0]  CMD,
  output logic                  MODE,
  output logic                  CIN,
  output logic                  CE,
  output logic [1:0]            INP_VALID,
  input  logic [DATA_WIDTH+1:0] ALU_RES,
  input  logic                  ALU_COUT,
  input  logic                  ALU_OFLOW,
  input  logic                  ALU_G,
  input  logic                  ALU_E,
  input  logic                  ALU_L,
  input  logic                  ALU_ERR,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH+1:0] RSP_RES,
  output logic [5:0]            RSP_FLAGS,
  output logic                  RSP_TMO
);

  localparam logic [CMD_WIDTH-1:0] CmdMulInc = CMD_WIDTH'(CMD_MUL_INC);
  localparam logic [CMD_WIDTH-1:0] CmdMulShl = CMD_WIDTH'(CMD_MUL_SHL);
  localparam logic [4:0]           TmoLimit  = 5'(TMO_LIMIT);
  localparam logic [4:0]           ResLat    = 5'(RES_LAT);
  localparam logic [4:0]           MultLat   = 5'(MULT_LAT);

  state_e                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_opa, r_opb;
  logic [CMD_WIDTH-1:0]  r_cmd;
  logic                  r_mode, r_cin;
  logic [1:0]            r_split;
  logic [4:0]            r_gap, r_lat, r_cnt;
  logic [DATA_WIDTH+1:0] r_res, w_res_def;
  logic [5:0]            r_flags, w_flags_def;
  logic                  r_tmo;
  logic                  w_accept, w_is_split, w_cnt_zero, w_capture;

  assign w_accept   = (r_state == StIdle) && REQ_VALID;
  assign w_is_split = (r_split == SPLIT_A_B) || (r_split == SPLIT_B_A);
  assign w_cnt_zero = (r_cnt == 5'd0);
  assign w_capture  = (r_state == StWait) && w_cnt_zero;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (REQ_VALID) w_state_next = StBeat1;
      StBeat1: begin
        if (!w_is_split)        w_state_next = StWait;
        else if (r_gap != 5'd0) w_state_next = StGap;
        else                    w_state_next = StBeat2;
      end
      StGap:   if (w_cnt_zero) w_state_next = StBeat2;
      StBeat2: w_state_next = StWait;
      StWait:  if (w_cnt_zero) w_state_next = StResp;
      StResp:  if (RSP_READY) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    INP_VALID = IV_NONE;
    unique case (r_state)
      StBeat1: begin
        if (r_split == SPLIT_A_B)      INP_VALID = IV_A;
        else if (r_split == SPLIT_B_A) INP_VALID = IV_B;
        else                           INP_VALID = IV_AB;
      end
      StBeat2: INP_VALID = (r_split == SPLIT_B_A) ? IV_A : IV_B;
      default: INP_VALID = IV_NONE;
    endcase
  end

  assign REQ_READY = (r_state == StIdle);
  assign RSP_VALID = (r_state == StResp);
  assign CE        = (r_state != StIdle) && (r_state != StResp);
  assign OPA       = r_opa;
  assign OPB       = r_opb;
  assign CMD       = r_cmd;
  assign MODE      = r_mode;
  assign CIN       = r_cin;
  assign RSP_RES   = r_res;
  assign RSP_FLAGS = r_flags;
  assign RSP_TMO   = r_tmo;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_cmd   <= '0;
      r_mode  <= 1'b0;
      r_cin   <= 1'b0;
      r_split <= SPLIT_AB;
      r_gap   <= 5'd0;
      r_lat   <= 5'd0;
    end else if (w_accept) begin
      r_opa   <= REQ_OPA;
      r_opb   <= REQ_OPB;
      r_cmd   <= REQ_CMD;
      r_mode  <= REQ_MODE;
      r_cin   <= REQ_CIN;
      r_split <= (REQ_SPLIT == SPLIT_AB_ALT) ? SPLIT_AB : REQ_SPLIT;
      r_gap   <= REQ_GAP;
      r_lat   <= ((REQ_MODE == MODE_ARITH) && ((REQ_CMD == CmdMulInc) ||
                  (REQ_CMD == CmdMulShl))) ? MultLat : ResLat;
    end
  end

  // One saturating down-counter serves both the gap and the result wait.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= 5'd0;
    end else begin
      unique case (r_state)
        StBeat1: begin
          if (!w_is_split)        r_cnt <= r_lat;
          else if (r_gap != 5'd0) r_cnt <= r_gap - 5'd1;
          else                    r_cnt <= 5'd0;
        end
        StBeat2:       r_cnt <= r_lat;
        StGap, StWait: r_cnt <= w_cnt_zero ? 5'd0 : r_cnt - 5'd1;
        default:       r_cnt <= r_cnt;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DATA_WIDTH + 2; i++) w_res_def[i] = definite_one(ALU_RES[i]);
    w_flags_def            = '0;
    w_flags_def[FLAG_COUT]  = definite_one(ALU_COUT);
    w_flags_def[FLAG_OFLOW] = definite_one(ALU_OFLOW);
    w_flags_def[FLAG_G]     = definite_one(ALU_G);
    w_flags_def[FLAG_E]     = definite_one(ALU_E);
    w_flags_def[FLAG_L]     = definite_one(ALU_L);
    w_flags_def[FLAG_ERR]   = definite_one(ALU_ERR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_res   <= '0;
      r_flags <= '0;
      r_tmo   <= 1'b0;
    end else if (w_capture) begin
      r_res   <= w_res_def;
      r_flags <= w_flags_def;
      r_tmo   <= w_is_split && (r_gap >= TmoLimit);
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a small behavioural ALU on the operand bus.
module tb_alu_op_issuer;
  import alu_if_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_VALID = 1'b0, REQ_READY;
  logic [7:0] REQ_OPA = '0, REQ_OPB = '0;
  logic [3:0] REQ_CMD = '0;
  logic       REQ_MODE = 1'b0, REQ_CIN = 1'b0;
  logic [1:0] REQ_SPLIT = '0;
  logic [4:0] REQ_GAP = '0;
  logic [7:0] OPA, OPB;
  logic [3:0] CMD;
  logic       MODE, CIN, CE;
  logic [1:0] INP_VALID;
  logic [9:0] ALU_RES;
  logic       ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR;
  logic       RSP_VALID, RSP_READY = 1'b0;
  logic [9:0] RSP_RES;
  logic [5:0] RSP_FLAGS;
  logic       RSP_TMO;

  int n_chk = 0;
  int n_bad = 0;
  int t_lat;
  logic [1:0] iv_log [0:63];

  always #5 CLK = ~CLK;

  alu_op_issuer dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CMD(REQ_CMD), .REQ_MODE(REQ_MODE),
    .REQ_CIN(REQ_CIN), .REQ_SPLIT(REQ_SPLIT), .REQ_GAP(REQ_GAP),
    .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE), .CIN(CIN), .CE(CE),
    .INP_VALID(INP_VALID), .ALU_RES(ALU_RES), .ALU_COUT(ALU_COUT), .ALU_OFLOW(ALU_OFLOW),
    .ALU_G(ALU_G), .ALU_E(ALU_E), .ALU_L(ALU_L), .ALU_ERR(ALU_ERR),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RES(RSP_RES),
    .RSP_FLAGS(RSP_FLAGS), .RSP_TMO(RSP_TMO)
  );

  // Behavioural ALU: latches operands on valid beats, raises ERR on a long split gap.
  logic [7:0] m_a, m_b;
  logic [4:0] m_gcnt;
  logic       m_pend, m_err;
  logic [8:0] m_sum;
  logic [9:0] m_mul;

  always @(posedge CLK) begin
    if (RST) begin
      m_a <= '0; m_b <= '0; m_gcnt <= '0; m_pend <= 1'b0; m_err <= 1'b0;
    end else if (CE) begin
      if (INP_VALID[0]) m_a <= OPA;
      if (INP_VALID[1]) m_b <= OPB;
      case (INP_VALID)
        2'b11: begin m_pend <= 1'b0; m_err <= 1'b0; end
        2'b01, 2'b10: begin
          if (!m_pend) begin
            m_pend <= 1'b1; m_gcnt <= '0; m_err <= 1'b0;
          end else begin
            m_pend <= 1'b0; m_err <= (m_gcnt >= 5'd16);
          end
        end
        default: if (m_pend && m_gcnt != 5'd31) m_gcnt <= m_gcnt + 5'd1;
      endcase
    end
  end

  always_comb begin
    m_sum = {1'b0, m_a} + {1'b0, m_b} + {8'd0, CIN};
    m_mul = ({2'b00, m_a} + 10'd1) * ({2'b00, m_b} + 10'd1);
    ALU_RES = '0; ALU_COUT = 1'b0; ALU_OFLOW = 1'b0;
    ALU_G = 1'b0; ALU_E = 1'b0; ALU_L = 1'b0;
    ALU_ERR = m_err;
    if (MODE) begin
      case (CMD)
        4'd0: begin ALU_RES = {1'b0, m_sum}; ALU_COUT = m_sum[8]; end
        4'd8: begin ALU_G = (m_a > m_b); ALU_E = (m_a == m_b); ALU_L = (m_a < m_b); end
        4'd9: ALU_RES = m_mul;
        default: ALU_RES = '0;
      endcase
    end else if (CMD == 4'd0) begin
      ALU_RES = {2'b00, m_a & m_b};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Issues one request, logs INP_VALID per cycle after accept, and stops at RSP_VALID.
  task automatic run_txn(input logic [1:0] split, input logic [4:0] gap, input logic mode,
                         input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
    @(negedge CLK);
    chk("req_ready_idle", 32'(REQ_READY), 32'd1);
    REQ_SPLIT = split; REQ_GAP = gap; REQ_MODE = mode; REQ_CMD = cmd;
    REQ_OPA = a; REQ_OPB = b; REQ_CIN = cin; REQ_VALID = 1'b1;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    t_lat = 0;
    for (int k = 0; k < 64; k++) iv_log[k] = 2'b00;
    for (int k = 1; k < 60; k++) begin
      @(negedge CLK);
      iv_log[k] = INP_VALID;
      if (RSP_VALID) begin
        t_lat = k;
        break;
      end
    end
  endtask

  task automatic ack();
    @(negedge CLK);
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1 RSP_READY = 1'b0;
  endtask

  initial begin
    logic seen;
    repeat (3) @(negedge CLK);
    chk("rst_req_ready", 32'(REQ_READY), 32'd1);
    chk("rst_outs", {22'd0, INP_VALID, CE, RSP_VALID, RSP_TMO, OPA[0], OPB[0], CMD[0], MODE, CIN},
        32'd0);
    chk("rst_rsp", {16'd0, RSP_RES, RSP_FLAGS}, 32'd0);
    RST = 1'b0;

    // Joint beat add: 0F + 01
    run_txn(2'b00, 5'd0, 1'b1, 4'd0, 8'h0F, 8'h01, 1'b0);
    chk("t1_lat", t_lat, 32'd4);
    chk("t1_iv", {iv_log[1], iv_log[2], iv_log[3]}, {2'b11, 2'b00, 2'b00});
    chk("t1_res", 32'(RSP_RES), 32'h010);
    chk("t1_flags", 32'(RSP_FLAGS), 32'd0);
    ack();

    // A then B, gap 3, logical AND
    run_txn(2'b01, 5'd3, 1'b0, 4'd0, 8'hF0, 8'h3C, 1'b0);
    chk("t2_iv", {iv_log[1], iv_log[2], iv_log[3], iv_log[4], iv_log[5]},
        {2'b01, 2'b00, 2'b00, 2'b00, 2'b10});
    chk("t2_lat", t_lat, 32'd8);
    chk("t2_res", 32'(RSP_RES), 32'h030);
    chk("t2_tmo", 32'(RSP_TMO), 32'd0);
    ack();

    // B then A, gap at the timeout limit
    run_txn(2'b10, 5'd16, 1'b1, 4'd0, 8'h03, 8'h04, 1'b0);
    chk("t3_iv", {iv_log[1], iv_log[2], iv_log[17], iv_log[18]},
        {2'b10, 2'b00, 2'b00, 2'b01});
    chk("t3_lat", t_lat, 32'd21);
    chk("t3_tmo", 32'(RSP_TMO), 32'd1);
    chk("t3_flags", 32'(RSP_FLAGS), 32'b000001);
    chk("t3_res", 32'(RSP_RES), 32'h007);
    ack();

    // Two-stage command: longer wait
    run_txn(2'b00, 5'd0, 1'b1, 4'd9, 8'd2, 8'd3, 1'b0);
    chk("t4_lat", t_lat, 32'd6);
    chk("t4_res", 32'(RSP_RES), 32'd12);
    ack();

    // Compare equal, response held under backpressure
    run_txn(2'b00, 5'd0, 1'b1, 4'd8, 8'd5, 8'd5, 1'b0);
    chk("t5_flags", 32'(RSP_FLAGS), 32'b000100);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("t5_hold", {20'd0, RSP_VALID, REQ_READY, RSP_FLAGS, RSP_RES[3:0]},
          {20'd0, 1'b1, 1'b0, 6'b000100, 4'd0});
    end
    ack();
    chk("t5_after_ack", {30'd0, REQ_READY, RSP_VALID}, {30'd0, 1'b1, 1'b0});

    // Split with zero gap, carry in
    run_txn(2'b01, 5'd0, 1'b1, 4'd0, 8'h10, 8'h20, 1'b1);
    chk("t6_iv", {iv_log[1], iv_log[2], iv_log[3]}, {2'b01, 2'b10, 2'b00});
    chk("t6_lat", t_lat, 32'd5);
    chk("t6_res", 32'(RSP_RES), 32'h031);
    ack();

    // SPLIT=11 behaves as joint; carry out
    run_txn(2'b11, 5'd7, 1'b1, 4'd0, 8'hFF, 8'h01, 1'b0);
    chk("t7_iv", 32'(iv_log[1]), 32'd3);
    chk("t7_lat", t_lat, 32'd4);
    chk("t7_res", 32'(RSP_RES), 32'h100);
    chk("t7_flags", 32'(RSP_FLAGS), 32'b100000);
    chk("t7_tmo", 32'(RSP_TMO), 32'd0);
    ack();

    // Maximum gap
    run_txn(2'b01, 5'd31, 1'b0, 4'd0, 8'hFF, 8'h0F, 1'b0);
    chk("t8_iv", {iv_log[32], iv_log[33]}, {2'b00, 2'b10});
    chk("t8_lat", t_lat, 32'd36);
    chk("t8_res", 32'(RSP_RES), 32'h00F);
    chk("t8_tmo", 32'(RSP_TMO), 32'd1);
    ack();

    // Reset during GAP drops the transaction
    @(negedge CLK);
    REQ_SPLIT = 2'b01; REQ_GAP = 5'd10; REQ_MODE = 1'b1; REQ_CMD = 4'd0;
    REQ_VALID = 1'b1;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    chk("t9_in_gap", {29'd0, CE, INP_VALID}, {29'd0, 1'b1, 2'b00});
    #1 RST = 1'b1;
    #1 chk("t9_rst", {29'd0, REQ_READY, INP_VALID}, {29'd0, 1'b1, 2'b00});
    @(negedge CLK);
    RST = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (RSP_VALID) seen = 1'b1;
    end
    chk("t9_no_rsp", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
